stack_seq: RTL and testbench
============================

// Module: stack_seq
// PURPOSE
//  Sequencer for the 8-bit stack pointer counter (s_load/s_up/s_cnt_enb interface).
//  Executes multi-byte push/pull and S-load commands from the CPU control unit.
//  Generates stack-page memory strobes and addresses, and paces the pointer updates.
//  Sits between the decode/control FSM, the S register and the memory bus mux.
// PARAMETERS
//  STACK_PAGE  8'h01  high address byte of the stack page
//  LEN_W       2      width of byte-count field (max 3 bytes per command)
// PORTS
//  clk        in   1      system clock, rising edge
//  reset_n    in   1      asynchronous reset, active low
//  req        in   1      command request; accepted on a clk edge while rdy_o=1
//  cmd        in   2      00 NOP, 01 PUSH, 10 PULL, 11 LOAD (S <= bus)
//  len        in   LEN_W  byte count for PUSH/PULL; ignored for LOAD/NOP
//  rdy        in   1      bus ready; 0 stalls the active sequence
//  sp_in      in   8      current S value (S register datao)
//  rdy_o      out  1      1 in IDLE: able to accept req
//  done       out  1      one-cycle pulse when a command completes
//  s_load     out  1      S register load enable
//  s_up       out  1      S count direction, 1=up
//  s_cnt_enb  out  1      S count enable
//  mem_addr   out  16     {STACK_PAGE, sp_in}
//  mem_we     out  1      stack write strobe
//  mem_re     out  1      stack read strobe
//  byte_idx   out  LEN_W  index of the byte being transferred
// BEHAVIOUR
//  - Reset: async to IDLE. rdy_o=1; done, s_load, s_up, s_cnt_enb, mem_we, mem_re=0;
//    byte_idx=0. A command in progress is abandoned with no done pulse.
//  - FSM states: IDLE, PUSH, PULL_INC, PULL_RD, LOAD, DONE.
//  - IDLE, req=1 at the edge:
//    - Latches cmd and len, then moves to PUSH / PULL_INC / LOAD.
//    - cmd=NOP, or len=0 with PUSH/PULL, moves to DONE with no bus access.
//  - req while rdy_o=0 is ignored; the requester holds req until it is accepted.
//  - PUSH (one cycle per byte):
//    - Outputs: mem_we=1, s_cnt_enb=1, s_up=0. Data is written at the current S,
//      then S decrements at the edge.
//    - byte_idx runs len-1 down to 0. After byte 0, the FSM moves to DONE.
//  - PULL_INC: s_cnt_enb=1, s_up=1, no memory strobe; moves to PULL_RD.
//  - PULL_RD:
//    - Outputs: mem_re=1 at the incremented S. byte_idx runs 0 up to len-1.
//    - If bytes remain, s_cnt_enb=1 and s_up=1 in the same cycle (overlapped increment).
//    - After the last byte, no increment and the FSM moves to DONE.
//  - Pull total: len+1 cycles.
//  - LOAD: s_load=1 for one cycle, then DONE. s_load and s_cnt_enb are never both 1.
//  - DONE: done=1 for one cycle, then IDLE. rdy_o=1 again the following cycle.
//  - Stall: rdy=0 in PUSH/PULL_INC/PULL_RD/LOAD.
//    - State and byte_idx hold.
//    - mem_we, mem_re, s_cnt_enb and s_load are forced to 0.
//    - The sequence resumes unchanged when rdy=1. DONE is not stalled.
//  - Wrap: S is modulo 256. Push at 8'h00 writes 0x0100 and S becomes 8'hFF;
//    pull at 8'hFF increments S to 8'h00. No trap is raised.
//  - mem_addr is combinational {STACK_PAGE, sp_in} in every state.
// CONFIGURATION
//  STACK_WRAP_DET_EN defined:
//    - Adds output wrap_flag (1 bit, reset 0, sticky).
//    - Set when a PUSH write issues with sp_in=8'h00.
//    - Set when a pull increment issues with sp_in=8'hFF.
//    - Cleared only by reset or a LOAD command.
//  STACK_WRAP_DET_EN undefined: port and logic absent; wrap behaviour as above.
// TESTING (bench models S register: load/inc/dec on clk)
//  1. reset_n=0 mid-PUSH -> all strobes 0, rdy_o=1, no done; next req is accepted normally.
//  2. PUSH len=3, S=FD -> mem_we 3 cycles at 01FD, 01FC, 01FB; byte_idx 2,1,0;
//     done next cycle; S=FA.
//  3. PULL len=2, S=FA -> INC cycle (no strobe), reads 01FB idx0 and 01FC idx1;
//     S=FC; done on cycle 4.
//  4. LOAD with bus=8'h7F -> s_load=1 one cycle, s_cnt_enb=0, S=7F, done next cycle.
//  5. PUSH len=2 with rdy=0 for 2 cycles after byte 1 -> no we/cnt_enb while stalled;
//     addresses follow in sequence; S decrements by 2 in total.
//  6. [STACK_WRAP_DET_EN] PUSH len=1 at S=00 -> write 0100, S=FF, wrap_flag=1;
//     a following LOAD clears wrap_flag.

Source files
------------

// File: rtl/stack_seq.sv
// Stack pointer sequencer: paces S-register push/pull/load and drives stack-page strobes.
// Optional STACK_WRAP_DET_EN adds a sticky wrap_flag output for page wrap-around detection.
module stack_seq #(
  parameter logic [7:0] STACK_PAGE = 8'h01,
  parameter int         LEN_W      = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [1:0]       cmd,
  input  logic [LEN_W-1:0] len,
  input  logic             rdy,
  input  logic [7:0]       sp_in,
  output logic             rdy_o,
  output logic             done,
  output logic             s_load,
  output logic             s_up,
  output logic             s_cnt_enb,
  output logic [15:0]      mem_addr,
  output logic             mem_we,
  output logic             mem_re,
  output logic [LEN_W-1:0] byte_idx
`ifdef STACK_WRAP_DET_EN
  ,
  output logic             wrap_flag
`endif
);

  typedef enum logic [2:0] {IDLE, PUSH, PULL_INC, PULL_RD, LOAD, DONE} state_t;

  localparam logic [1:0]       CMD_PUSH = 2'b01;
  localparam logic [1:0]       CMD_PULL = 2'b10;
  localparam logic [1:0]       CMD_LOAD = 2'b11;
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             last_rd;

  assign last_rd = (idx_q == len_q - ONE);

  // NOTE: defaulting every variable first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          len_d = len;
          idx_d = '0;
          case (cmd)
            CMD_PUSH: begin
              state_d = (len == '0) ? DONE : PUSH;
              idx_d   = len - ONE;
            end
            CMD_PULL: state_d = (len == '0) ? DONE : PULL_INC;
            CMD_LOAD: state_d = LOAD;
            default:  state_d = DONE;
          endcase
          if (len == '0) idx_d = '0;
        end
      end
      PUSH: begin
        if (rdy) begin
          if (idx_q == '0) state_d = DONE;
          else             idx_d   = idx_q - ONE;
        end
      end
      PULL_INC: if (rdy) state_d = PULL_RD;
      PULL_RD: begin
        if (rdy) begin
          if (last_rd) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      LOAD:    if (rdy) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

  // Strobes are state decodes gated by rdy so a stalled cycle issues nothing.
  assign rdy_o     = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign mem_we    = (state_q == PUSH) && rdy;
  assign mem_re    = (state_q == PULL_RD) && rdy;
  assign s_load    = (state_q == LOAD) && rdy;
  assign s_up      = (state_q == PULL_INC) || (state_q == PULL_RD);
  assign s_cnt_enb = rdy && ((state_q == PUSH) || (state_q == PULL_INC) ||
                             ((state_q == PULL_RD) && !last_rd));
  assign mem_addr  = {STACK_PAGE, sp_in};
  assign byte_idx  = idx_q;

`ifdef STACK_WRAP_DET_EN
  logic wrap_q, wrap_d;

  always_comb begin
    wrap_d = wrap_q;
    if ((state_q == IDLE) && req && (cmd == CMD_LOAD)) wrap_d = 1'b0;
    if ((mem_we && (sp_in == 8'h00)) || (s_cnt_enb && s_up && (sp_in == 8'hFF)))
      wrap_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wrap_q <= 1'b0;
    else          wrap_q <= wrap_d;
  end

  assign wrap_flag = wrap_q;
`endif

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: models the S register and scoreboards per-cycle outputs.
// Define STACK_WRAP_DET_EN for both files to also exercise wrap_flag.
module tb_stack_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic [1:0]  cmd;
  logic [1:0]  len;
  logic        rdy;
  logic [7:0]  sp_m = 8'h00;
  logic [7:0]  bus_m = 8'h00;
  logic        rdy_o, done, s_load, s_up, s_cnt_enb, mem_we, mem_re;
  logic [15:0] mem_addr;
  logic [1:0]  byte_idx;
`ifdef STACK_WRAP_DET_EN
  logic        wrap_flag;
`endif

  stack_seq #(.STACK_PAGE(8'h01), .LEN_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .cmd(cmd), .len(len), .rdy(rdy),
    .sp_in(sp_m), .rdy_o(rdy_o), .done(done), .s_load(s_load), .s_up(s_up),
    .s_cnt_enb(s_cnt_enb), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .byte_idx(byte_idx)
`ifdef STACK_WRAP_DET_EN
    , .wrap_flag(wrap_flag)
`endif
  );

  always #5 clk = ~clk;

  // S register model: load from the bus, or count up/down.
  always @(posedge clk) begin
    if (s_load)         sp_m <= bus_m;
    else if (s_cnt_enb) sp_m <= s_up ? sp_m + 8'h01 : sp_m - 8'h01;
  end

  typedef struct packed {
    logic [23:0] v;
    logic        rdy;
    logic        up_chk;
    logic        up;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_k;
  int   stall_at;
  int   stall_n;

  localparam logic [23:0] STROBE_MASK = 24'h3C0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [23:0] vec(input logic ro, input logic d, input logic we,
                                      input logic re, input logic cnt, input logic ld,
                                      input logic [1:0] idx, input logic [7:0] a);
    return {ro, d, we, re, cnt, ld, idx, 8'h01, a};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {rdy_o, done, mem_we, mem_re, s_cnt_enb, s_load, byte_idx, mem_addr};
  endfunction

  task automatic add(input logic [23:0] v, input logic cnt, input logic up);
    exp_t e;
    if (step_k == stall_at) begin
      for (int i = 0; i < stall_n; i++) begin
        e = '{v & ~STROBE_MASK, 1'b0, 1'b0, 1'b0};
        sb.push_back(e);
      end
    end
    e = '{v, 1'b1, cnt, up};
    sb.push_back(e);
    step_k++;
  endtask

  task automatic run(input logic [1:0] c, input logic [1:0] n, input int s_at,
                     input int s_n, input logic [7:0] bus);
    logic [7:0] s, s_end, a;
    int         nn;
    exp_t       e;
    s        = sp_m;
    nn       = int'(n);
    step_k   = 0;
    stall_at = s_at;
    stall_n  = s_n;
    bus_m    = bus;
    s_end    = s;
    if (c == 2'b01 && nn != 0) begin
      for (int j = 0; j < nn; j++) begin
        a = s - j[7:0];
        add(vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'(nn - 1 - j), a), 1'b1, 1'b0);
      end
      s_end = s - n;
    end else if (c == 2'b10 && nn != 0) begin
      add(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, s), 1'b1, 1'b1);
      for (int k = 0; k < nn; k++) begin
        a = s + 8'h01 + k[7:0];
        add(vec(1'b0, 1'b0, 1'b0, 1'b1, k != nn - 1, 1'b0, 2'(k), a), k != nn - 1, 1'b1);
      end
      s_end = s + n;
    end else if (c == 2'b11) begin
      add(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, s), 1'b0, 1'b0);
      s_end = bus;
    end
    e = '{vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, s_end), 1'b1, 1'b0, 1'b0};
    sb.push_back(e);

    @(negedge clk);
    req = 1'b1; cmd = c; len = n; rdy = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      req = 1'b0;
      rdy = e.rdy;
      #1;
      check("seq", 32'(dut_vec()), 32'(e.v));
      if (e.up_chk) check("s_up", 32'(s_up), 32'(e.up));
    end
    @(negedge clk);
    rdy = 1'b1;
    #1;
    check("idle", 32'(dut_vec()), 32'(vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, s_end)));
    check("sp", 32'(sp_m), 32'(s_end));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; req = 1'b0; cmd = 2'b00; len = 2'd0; rdy = 1'b1;
    #2;
    check("reset", 32'(dut_vec()), 32'(vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00)));
    check("reset_up", 32'(s_up), 32'd0);
`ifdef STACK_WRAP_DET_EN
    check("reset_wrap", 32'(wrap_flag), 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run(2'b11, 2'd0, -1, 0, 8'hFD);   // load S=FD
    run(2'b01, 2'd3, -1, 0, 8'h00);   // push 3 -> FA
    run(2'b10, 2'd2, -1, 0, 8'h00);   // pull 2 -> FC
    run(2'b11, 2'd1, -1, 0, 8'h7F);   // load 7F, len ignored
    run(2'b01, 2'd2, 1, 2, 8'h00);    // push 2, stalled after byte 1
    run(2'b10, 2'd3, 2, 1, 8'h00);    // pull 3, stalled mid-read
    run(2'b10, 2'd1, 0, 2, 8'h00);    // pull 1, stalled on the increment
    run(2'b00, 2'd2, -1, 0, 8'h00);   // NOP
    run(2'b01, 2'd0, -1, 0, 8'h00);   // push len 0
    run(2'b10, 2'd0, -1, 0, 8'h00);   // pull len 0

    run(2'b11, 2'd0, -1, 0, 8'h00);
    run(2'b01, 2'd1, -1, 0, 8'h00);   // push at 00 -> writes 0100, S=FF
`ifdef STACK_WRAP_DET_EN
    check("wrap_push", 32'(wrap_flag), 32'd1);
`endif
    run(2'b11, 2'd0, -1, 0, 8'hFF);
`ifdef STACK_WRAP_DET_EN
    check("wrap_clr", 32'(wrap_flag), 32'd0);
`endif
    run(2'b10, 2'd1, -1, 0, 8'h00);   // pull at FF -> S=00
`ifdef STACK_WRAP_DET_EN
    check("wrap_pull", 32'(wrap_flag), 32'd1);
`endif

    // Abandon a push mid-sequence with reset.
    run(2'b11, 2'd0, -1, 0, 8'h50);
    @(negedge clk);
    req = 1'b1; cmd = 2'b01; len = 2'd3;
    @(negedge clk);
    req = 1'b0;
    #1;
    check("mid_push", 32'(dut_vec()), 32'(vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'h50)));
    reset_n = 1'b0;
    #1;
    check("rst_async", 32'(dut_vec()), 32'(vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h50)));
    @(negedge clk);
    #1;
    check("rst_hold", 32'(dut_vec()), 32'(vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h50)));
`ifdef STACK_WRAP_DET_EN
    check("rst_wrap", 32'(wrap_flag), 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_nodone", 32'(dut_vec()), 32'(vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h50)));
    run(2'b01, 2'd1, -1, 0, 8'h00);   // push accepted normally after reset

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
